dac_tdm_sched: RTL



---
 rtl/dac_sched_pkg.sv | 28 ++
 rtl/dac_code_conv.sv | 27 ++
 rtl/dac_tdm_sched.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dac_sched_pkg.sv
// rtl/dac_sched_pkg.sv - shared state type and sizing helpers for the DAC TDM scheduler
package dac_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE_L,
      HOLD_L,
      DRIVE_R,
      HOLD_R
   } state_t;

   localparam int DEF_SETTLE = 4;
   localparam int DEF_HOLD   = 2;

   // One counter times every phase, so it must reach max(settle, hold) - 1.
   function automatic int cnt_width(input int settle, input int hold);
      int m;
      m = (settle > hold) ? settle : hold;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   localparam int CNT_W = cnt_width(DEF_SETTLE, DEF_HOLD);

   function automatic logic [31:0] midscale(input int width);
      return 32'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/dac_code_conv.sv
// rtl/dac_code_conv.sv - signed sample to offset-binary DAC code (truncating)
module dac_code_conv
   import dac_sched_pkg::*;
#(
   parameter int IN_W  = 32,
   parameter int DAC_W = 8
) (
   input  logic [IN_W-1:0]  sample,
   output logic [DAC_W-1:0] code
);

   localparam logic [DAC_W-1:0] MID = DAC_W'(midscale(DAC_W));

   logic [DAC_W-1:0] w_top;

   assign w_top = sample[IN_W-1 -: DAC_W];
   assign code  = w_top ^ MID;

   // Bits below the DAC resolution are deliberately discarded.
   generate
      if (IN_W > DAC_W) begin : g_lsbs
         logic w_unused_lsbs;
         assign w_unused_lsbs = ^sample[IN_W-DAC_W-1:0];
      end
   endgenerate

endmodule

// File: rtl/dac_tdm_sched.sv
// rtl/dac_tdm_sched.sv - time-multiplexes one R2R DAC port between left and right channels
module dac_tdm_sched
   import dac_sched_pkg::*;
#(
   parameter int IN_W   = 32,
   parameter int DAC_W  = 8,
   parameter int SETTLE = 4,
   parameter int HOLD   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  sample_l,
   input  logic [IN_W-1:0]  sample_r,
   input  logic             sample_stb,
   input  logic             mute,
   input  logic             clr_ovr,
   output logic [DAC_W-1:0] dac_dat,
   output logic             sh_l,
   output logic             sh_r,
   output logic             busy,
   output logic             overrun
);

   localparam int              CW        = cnt_width(SETTLE, HOLD);
   localparam logic [DAC_W-1:0] MID      = DAC_W'(midscale(DAC_W));
   localparam logic [CW-1:0]   SET_LAST  = CW'(SETTLE - 1);
   localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD - 1);

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [DAC_W-1:0] r_code_l, r_code_r, r_pend_l, r_pend_r;
   logic             r_pend_valid, r_ovr;
   logic [DAC_W-1:0] w_in_l, w_in_r, w_src_l, w_src_r;
   logic             w_last, w_load, w_from_pend, w_pend_wr, w_pend_clr, w_ovr_set;

   dac_code_conv #(.IN_W(IN_W), .DAC_W(DAC_W)) u_conv_l (.sample(sample_l), .code(w_in_l));
   dac_code_conv #(.IN_W(IN_W), .DAC_W(DAC_W)) u_conv_r (.sample(sample_r), .code(w_in_r));

   assign w_src_l = w_from_pend ? r_pend_l : w_in_l;
   assign w_src_r = w_from_pend ? r_pend_r : w_in_r;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CW'(1);
      w_last      = 1'b0;
      w_load      = 1'b0;
      w_from_pend = 1'b0;
      w_pend_wr   = 1'b0;
      w_pend_clr  = 1'b0;
      w_ovr_set   = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (sample_stb) begin
               w_load      = 1'b1;
               w_state_nxt = DRIVE_L;
            end
         end
         DRIVE_L: if (r_cnt == SET_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = HOLD_L;
         end
         HOLD_L: if (r_cnt == HOLD_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = DRIVE_R;
         end
         DRIVE_R: if (r_cnt == SET_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = HOLD_R;
         end
         HOLD_R: if (r_cnt == HOLD_LAST) begin
            w_last    = 1'b1;
            w_cnt_nxt = '0;
            // A strobe on the frame boundary beats anything waiting in pending.
            if (sample_stb) begin
               w_load      = 1'b1;
               w_pend_clr  = 1'b1;
               w_ovr_set   = r_pend_valid;
               w_state_nxt = DRIVE_L;
            end else if (r_pend_valid) begin
               w_load      = 1'b1;
               w_from_pend = 1'b1;
               w_pend_clr  = 1'b1;
               w_state_nxt = DRIVE_L;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
      if (sample_stb && (r_state != IDLE) && !w_last) begin
         w_pend_wr = 1'b1;
         w_ovr_set = r_pend_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_code_l     <= MID;
         r_code_r     <= MID;
         r_pend_l     <= MID;
         r_pend_r     <= MID;
         r_pend_valid <= 1'b0;
         r_ovr        <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_load) begin
            r_code_l <= mute ? MID : w_src_l;
            r_code_r <= mute ? MID : w_src_r;
         end
         if (w_pend_wr) begin
            r_pend_l     <= w_in_l;
            r_pend_r     <= w_in_r;
            r_pend_valid <= 1'b1;
         end else if (w_pend_clr) begin
            r_pend_valid <= 1'b0;
         end
         if (w_ovr_set) begin
            r_ovr <= 1'b1;
         end else if (clr_ovr) begin
            r_ovr <= 1'b0;
         end
      end
   end

   // In IDLE the R code stays on the port; after reset both codes are midscale.
   assign dac_dat = ((r_state == DRIVE_L) || (r_state == HOLD_L)) ? r_code_l : r_code_r;
   assign sh_l    = (r_state == HOLD_L);
   assign sh_r    = (r_state == HOLD_R);
   assign busy    = (r_state != IDLE);
   assign overrun = r_ovr;

endmodule
